control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the bus/datapath.
- Drives every datapath strobe that the datapath benches currently drive by hand: PCout, MARin, IncPC, Zin, Gra/Grb/Grc, Rin, Rout, BAout, etc.
- Steps through fetch (T0–T2) and per-opcode execute steps (T3–T7), using IR[31:27] as the opcode.
- Moore-style outputs: every strobe is decoded from the current state plus the latched IR; one control step per clock.

Parameters:
- OPW, 5, opcode width (IR[31:27])
- ALUW, 12, width of ALUControl

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  reset, synchronous, active-high
- IR  in  32  instruction register contents from the datapath
- CON  in  1  branch condition flip-flop output from the datapath
- PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRRead, IRin  out  1 each  PC/memory-path strobes
- RAMread, RAMwrite  out  1 each  memory strobes
- Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout  out  1 each  ALU and result register strobes
- Gra, Grb, Grc, Rin_in, Rout_in, BAout, r15write, Cout  out  1 each  register-select and immediate strobes
- CONin, con_FF_Reset, InPortout, OutPortIn  out  1 each  branch and I/O strobes
- ALUControl  out  ALUW  ALU operation: {7'b0, opcode} during ALU steps, else 0
- Run  out  1  1 = executing; 0 = halted

Behaviour:
- States: S_RST, T0..T7, S_HALT.
- clr sampled high at a clock edge → state S_RST. Outputs in S_RST: all strobes 0, ALUControl 0, Run 1.
- S_RST → T0 on the next edge with clr low.
- clr mid-instruction abandons the sequence; no partial RAMwrite follows.
- Any strobe not listed for a step is 0.
- The step that ends a sequence returns to T0 on the next edge.

Fetch (all opcodes):
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, RAMread, MDRRead, MDRin.
- T2: MDRout, IRin.
- T3 decodes the opcode from the new IR.

Execute, by opcode:
- Reg ALU (add 00011, sub, and, or, ror, rol, shr, shra, shl 01011):
  - T3: Grb, Rout_in, Yin.
  - T4: Grc, Rout_in, ALUControl = op, Zin.
  - T5: Zlowout, Gra, Rin_in.
- Immediate (addi 01100, andi, ori 01110):
  - T3: Grb, Rout_in, Yin.
  - T4: Cout, ALUControl = op, Zin.
  - T5: Zlowout, Gra, Rin_in.
- ldi 00001:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ALUControl = add, Zin.
  - T5: Zlowout, Gra, Rin_in.
- ld 00000:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: RAMread, MDRRead, MDRin.
  - T7: MDRout, Gra, Rin_in.
- st 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout_in, MDRin (MDRRead = 0).
  - T7: RAMwrite.
- div 01111, mul 10000:
  - T3: Gra, Rout_in, Yin.
  - T4: Grb, Rout_in, ALUControl = op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- neg 10001, not 10010:
  - T3: Grb, Rout_in, ALUControl = op, Zin.
  - T4: Zlowout, Gra, Rin_in.
- br 10011:
  - T3: Gra, Rout_in, CONin.
  - T4: PCout, Yin.
  - T5: Cout, ALUControl = add, Zin.
  - T6: con_FF_Reset; if CON = 1 also Zlowout and PCin, otherwise PC unchanged.
- jr 10100:
  - T3: Gra, Rout_in, PCin.
- jal 10101:
  - T3: PCout, r15write.
  - T4: Gra, Rout_in, PCin.
- Single-step moves, all at T3:
  - in 10110: InPortout, Gra, Rin_in.
  - out 10111: Gra, Rout_in, OutPortIn.
  - mfhi 11000: HIout, Gra, Rin_in.
  - mflo 11001: LOout, Gra, Rin_in.
- nop 11010 and undefined opcodes 11100–11111: T2 → T0 directly, no T3.
- halt 11011: T2 → S_HALT.
  - In S_HALT: Run = 0, all strobes 0.
  - Leaves S_HALT only on clr.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams (5-bit encodings above);
  - state encoding;
  - ALUW and OPW.
- One sub-module, op_class_decode: combinational; IR[31:27] → one-hot class (REG_ALU, IMM, LD, LDI, ST, MULDIV, UNARY, BR, JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT).

Test Plan:
- clr high 2 cycles then low:
  - outputs all 0 during reset;
  - T0 on the second cycle after clr falls with PCout = MARin = IncPC = Zin = 1;
  - Run = 1.
- IR = add R1,R2,R3 (0x18918000):
  - T3 Grb/Rout_in/Yin; T4 ALUControl = 0x003 with Zin; T5 Gra/Rin_in;
  - T0 reached 6 cycles after the prior T0.
- IR = st with C = 0x55:
  - MDRRead = 0 in T6;
  - RAMwrite = 1 only in T7;
  - 8-cycle instruction.
- br with CON = 0 → PCin never asserted in T3–T7; br with CON = 1 → PCin and Zlowout in T6; con_FF_Reset in T6 both cases.
- halt (0xD8000000) → Run = 0 from the cycle after T2, strobes stay 0 for 20 cycles; clr → restarts at T0.
- clr asserted during ld T5 → next cycle all strobes 0, no RAMread in the following cycle, fetch restarts.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer:
// opcode encodings, state encoding and instruction class indices.
package cpu_ctrl_pkg;

    localparam int OPW  = 5;
    localparam int ALUW = 12;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST,
        T0, T1, T2, T3, T4, T5, T6, T7,
        S_HALT
    } state_e;

    localparam int NCLS      = 16;
    localparam int C_REG_ALU = 0;
    localparam int C_IMM     = 1;
    localparam int C_LD      = 2;
    localparam int C_LDI     = 3;
    localparam int C_ST      = 4;
    localparam int C_MULDIV  = 5;
    localparam int C_UNARY   = 6;
    localparam int C_BR      = 7;
    localparam int C_JR      = 8;
    localparam int C_JAL     = 9;
    localparam int C_IN      = 10;
    localparam int C_OUT     = 11;
    localparam int C_MFHI    = 12;
    localparam int C_MFLO    = 13;
    localparam int C_NOP     = 14;
    localparam int C_HALT    = 15;

    typedef logic [NCLS-1:0] op_class_t;

    localparam logic [ALUW-1:0] ALU_ADD = {{(ALUW-OPW){1'b0}}, OP_ADD};

endpackage

// File: rtl/op_class_decode.sv
// Opcode to one-hot instruction class.
// Undefined opcodes fall into the NOP class.
module op_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    output op_class_t      cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                cls_o[C_REG_ALU] = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:
                cls_o[C_IMM] = 1'b1;
            OP_LD:   cls_o[C_LD]     = 1'b1;
            OP_LDI:  cls_o[C_LDI]    = 1'b1;
            OP_ST:   cls_o[C_ST]     = 1'b1;
            OP_DIV, OP_MUL:
                cls_o[C_MULDIV] = 1'b1;
            OP_NEG, OP_NOT:
                cls_o[C_UNARY] = 1'b1;
            OP_BR:   cls_o[C_BR]     = 1'b1;
            OP_JR:   cls_o[C_JR]     = 1'b1;
            OP_JAL:  cls_o[C_JAL]    = 1'b1;
            OP_IN:   cls_o[C_IN]     = 1'b1;
            OP_OUT:  cls_o[C_OUT]    = 1'b1;
            OP_MFHI: cls_o[C_MFHI]   = 1'b1;
            OP_MFLO: cls_o[C_MFLO]   = 1'b1;
            OP_HALT: cls_o[C_HALT]   = 1'b1;
            default: cls_o[C_NOP]    = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2 then per-class execute steps,
// Moore outputs decoded from the current step and the IR opcode.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     IR,
    input  logic            CON,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            MDRRead,
    output logic            IRin,
    output logic            RAMread,
    output logic            RAMwrite,
    output logic            Yin,
    output logic            Zin,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            HIin,
    output logic            HIout,
    output logic            LOin,
    output logic            LOout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin_in,
    output logic            Rout_in,
    output logic            BAout,
    output logic            r15write,
    output logic            Cout,
    output logic            CONin,
    output logic            con_FF_Reset,
    output logic            InPortout,
    output logic            OutPortIn,
    output logic [ALUW-1:0] ALUControl,
    output logic            Run
);

    state_e          state_q, state_d;
    op_class_t       cls;
    logic [OPW-1:0]  op;
    logic [ALUW-1:0] alu_op;
    logic            unused_ir;

    assign op        = IR[31:27];
    assign alu_op    = {{(ALUW-OPW){1'b0}}, op};
    assign unused_ir = ^IR[26:0];

    op_class_decode u_dec (
        .opcode_i (op),
        .cls_o    (cls)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_RST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        PCout        = 1'b0;
        PCin         = 1'b0;
        IncPC        = 1'b0;
        MARin        = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        MDRRead      = 1'b0;
        IRin         = 1'b0;
        RAMread      = 1'b0;
        RAMwrite     = 1'b0;
        Yin          = 1'b0;
        Zin          = 1'b0;
        Zhighout     = 1'b0;
        Zlowout      = 1'b0;
        HIin         = 1'b0;
        HIout        = 1'b0;
        LOin         = 1'b0;
        LOout        = 1'b0;
        Gra          = 1'b0;
        Grb          = 1'b0;
        Grc          = 1'b0;
        Rin_in       = 1'b0;
        Rout_in      = 1'b0;
        BAout        = 1'b0;
        r15write     = 1'b0;
        Cout         = 1'b0;
        CONin        = 1'b0;
        con_FF_Reset = 1'b0;
        InPortout    = 1'b0;
        OutPortIn    = 1'b0;
        ALUControl   = '0;
        Run          = 1'b1;

        case (state_q)
            S_RST: state_d = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1;
                IncPC = 1'b1; Zin   = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin    = 1'b1;
                RAMread = 1'b1; MDRRead = 1'b1;
                MDRin   = 1'b1;
                state_d = T2;
            end
            // nop/halt are resolved here so they never enter execute
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                if (cls[C_NOP])       state_d = T0;
                else if (cls[C_HALT]) state_d = S_HALT;
                else                  state_d = T3;
            end
            T3: begin
                state_d = T0;
                unique case (1'b1)
                    cls[C_REG_ALU], cls[C_IMM]: begin
                        Grb = 1'b1; Rout_in = 1'b1; Yin = 1'b1;
                        state_d = T4;
                    end
                    cls[C_LDI], cls[C_LD], cls[C_ST]: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                        state_d = T4;
                    end
                    cls[C_MULDIV]: begin
                        Gra = 1'b1; Rout_in = 1'b1; Yin = 1'b1;
                        state_d = T4;
                    end
                    cls[C_UNARY]: begin
                        Grb = 1'b1; Rout_in = 1'b1;
                        ALUControl = alu_op; Zin = 1'b1;
                        state_d = T4;
                    end
                    cls[C_BR]: begin
                        Gra = 1'b1; Rout_in = 1'b1; CONin = 1'b1;
                        state_d = T4;
                    end
                    cls[C_JR]: begin
                        Gra = 1'b1; Rout_in = 1'b1; PCin = 1'b1;
                    end
                    cls[C_JAL]: begin
                        PCout = 1'b1; r15write = 1'b1;
                        state_d = T4;
                    end
                    cls[C_IN]: begin
                        InPortout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                    end
                    cls[C_OUT]: begin
                        Gra = 1'b1; Rout_in = 1'b1; OutPortIn = 1'b1;
                    end
                    cls[C_MFHI]: begin
                        HIout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                    end
                    cls[C_MFLO]: begin
                        LOout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                    end
                    default: state_d = T0;
                endcase
            end
            T4: begin
                state_d = T5;
                unique case (1'b1)
                    cls[C_REG_ALU]: begin
                        Grc = 1'b1; Rout_in = 1'b1;
                        ALUControl = alu_op; Zin = 1'b1;
                    end
                    cls[C_IMM]: begin
                        Cout = 1'b1; ALUControl = alu_op; Zin = 1'b1;
                    end
                    cls[C_LDI], cls[C_LD], cls[C_ST]: begin
                        Cout = 1'b1; ALUControl = ALU_ADD; Zin = 1'b1;
                    end
                    cls[C_MULDIV]: begin
                        Grb = 1'b1; Rout_in = 1'b1;
                        ALUControl = alu_op; Zin = 1'b1;
                    end
                    cls[C_UNARY]: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                        state_d = T0;
                    end
                    cls[C_BR]: begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                    cls[C_JAL]: begin
                        Gra = 1'b1; Rout_in = 1'b1; PCin = 1'b1;
                        state_d = T0;
                    end
                    default: state_d = T0;
                endcase
            end
            T5: begin
                state_d = T6;
                unique case (1'b1)
                    cls[C_REG_ALU], cls[C_IMM], cls[C_LDI]: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                        state_d = T0;
                    end
                    cls[C_LD], cls[C_ST]: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    cls[C_MULDIV]: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    cls[C_BR]: begin
                        Cout = 1'b1; ALUControl = ALU_ADD; Zin = 1'b1;
                    end
                    default: state_d = T0;
                endcase
            end
            T6: begin
                state_d = T0;
                unique case (1'b1)
                    cls[C_LD]: begin
                        RAMread = 1'b1; MDRRead = 1'b1; MDRin = 1'b1;
                        state_d = T7;
                    end
                    // store data comes from Ra, not memory
                    cls[C_ST]: begin
                        Gra = 1'b1; Rout_in = 1'b1; MDRin = 1'b1;
                        state_d = T7;
                    end
                    cls[C_MULDIV]: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    cls[C_BR]: begin
                        con_FF_Reset = 1'b1;
                        Zlowout = CON; PCin = CON;
                    end
                    default: state_d = T0;
                endcase
            end
            T7: begin
                state_d = T0;
                unique case (1'b1)
                    cls[C_LD]: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin_in = 1'b1;
                    end
                    cls[C_ST]: RAMwrite = 1'b1;
                    default: state_d = T0;
                endcase
            end
            S_HALT: Run = 1'b0;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: expected per-cycle control words are queued per
// instruction, then popped and compared once per clock.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR  = 32'hD000_0000;
    logic        CON = 1'b0;

    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRRead, IRin;
    logic RAMread, RAMwrite;
    logic Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic Gra, Grb, Grc, Rin_in, Rout_in, BAout, r15write, Cout;
    logic CONin, con_FF_Reset, InPortout, OutPortIn;
    logic [11:0] ALUControl;
    logic Run;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .MDRRead(MDRRead),
        .IRin(IRin), .RAMread(RAMread), .RAMwrite(RAMwrite),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin_in(Rin_in),
        .Rout_in(Rout_in), .BAout(BAout), .r15write(r15write),
        .Cout(Cout), .CONin(CONin), .con_FF_Reset(con_FF_Reset),
        .InPortout(InPortout), .OutPortIn(OutPortIn),
        .ALUControl(ALUControl), .Run(Run)
    );

    localparam logic [29:0] S_PCOUT = 30'd1 << 0;
    localparam logic [29:0] S_PCIN  = 30'd1 << 1;
    localparam logic [29:0] S_INCPC = 30'd1 << 2;
    localparam logic [29:0] S_MARIN = 30'd1 << 3;
    localparam logic [29:0] S_MDRIN = 30'd1 << 4;
    localparam logic [29:0] S_MDROU = 30'd1 << 5;
    localparam logic [29:0] S_MDRRD = 30'd1 << 6;
    localparam logic [29:0] S_IRIN  = 30'd1 << 7;
    localparam logic [29:0] S_RAMRD = 30'd1 << 8;
    localparam logic [29:0] S_RAMWR = 30'd1 << 9;
    localparam logic [29:0] S_YIN   = 30'd1 << 10;
    localparam logic [29:0] S_ZIN   = 30'd1 << 11;
    localparam logic [29:0] S_ZHI   = 30'd1 << 12;
    localparam logic [29:0] S_ZLO   = 30'd1 << 13;
    localparam logic [29:0] S_HIIN  = 30'd1 << 14;
    localparam logic [29:0] S_HIOUT = 30'd1 << 15;
    localparam logic [29:0] S_LOIN  = 30'd1 << 16;
    localparam logic [29:0] S_LOOUT = 30'd1 << 17;
    localparam logic [29:0] S_GRA   = 30'd1 << 18;
    localparam logic [29:0] S_GRB   = 30'd1 << 19;
    localparam logic [29:0] S_GRC   = 30'd1 << 20;
    localparam logic [29:0] S_RIN   = 30'd1 << 21;
    localparam logic [29:0] S_ROUT  = 30'd1 << 22;
    localparam logic [29:0] S_BAOUT = 30'd1 << 23;
    localparam logic [29:0] S_R15W  = 30'd1 << 24;
    localparam logic [29:0] S_COUT  = 30'd1 << 25;
    localparam logic [29:0] S_CONIN = 30'd1 << 26;
    localparam logic [29:0] S_CONRS = 30'd1 << 27;
    localparam logic [29:0] S_INP   = 30'd1 << 28;
    localparam logic [29:0] S_OUTP  = 30'd1 << 29;

    localparam logic [11:0] A_ADD = 12'h003;

    logic [42:0] obs;
    assign obs = {Run, ALUControl,
                  OutPortIn, InPortout, con_FF_Reset, CONin,
                  Cout, r15write, BAout, Rout_in,
                  Rin_in, Grc, Grb, Gra,
                  LOout, LOin, HIout, HIin,
                  Zlowout, Zhighout, Zin, Yin,
                  RAMwrite, RAMread, IRin, MDRRead,
                  MDRout, MDRin, MARin, IncPC, PCin, PCout};

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        clr;
        logic [42:0] exp;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    function automatic logic [31:0] mk(logic [4:0] op, logic [3:0] ra,
                                       logic [3:0] rb, logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic push(logic [31:0] ir, logic con, logic cl,
                        logic run, logic [11:0] alu, logic [29:0] s,
                        string tag);
        sb_t e;
        e.ir = ir; e.con = con; e.clr = cl;
        e.exp = {run, alu, s}; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic push_instr(logic [31:0] ir, logic con, string nm);
        logic [4:0]  op;
        logic [11:0] a;
        op = ir[31:27];
        a  = {7'd0, op};
        push(ir, con, 0, 1, 0, S_PCOUT|S_MARIN|S_INCPC|S_ZIN, {nm, ".T0"});
        push(ir, con, 0, 1, 0,
             S_ZLO|S_PCIN|S_RAMRD|S_MDRRD|S_MDRIN, {nm, ".T1"});
        push(ir, con, 0, 1, 0, S_MDROU|S_IRIN, {nm, ".T2"});
        if (op >= 5'd3 && op <= 5'd11) begin
            push(ir, con, 0, 1, 0, S_GRB|S_ROUT|S_YIN, {nm, ".T3"});
            push(ir, con, 0, 1, a, S_GRC|S_ROUT|S_ZIN, {nm, ".T4"});
            push(ir, con, 0, 1, 0, S_ZLO|S_GRA|S_RIN, {nm, ".T5"});
        end else if (op >= 5'd12 && op <= 5'd14) begin
            push(ir, con, 0, 1, 0, S_GRB|S_ROUT|S_YIN, {nm, ".T3"});
            push(ir, con, 0, 1, a, S_COUT|S_ZIN, {nm, ".T4"});
            push(ir, con, 0, 1, 0, S_ZLO|S_GRA|S_RIN, {nm, ".T5"});
        end else if (op <= 5'd2) begin
            push(ir, con, 0, 1, 0, S_GRB|S_BAOUT|S_YIN, {nm, ".T3"});
            push(ir, con, 0, 1, A_ADD, S_COUT|S_ZIN, {nm, ".T4"});
            if (op == 5'd1) begin
                push(ir, con, 0, 1, 0, S_ZLO|S_GRA|S_RIN, {nm, ".T5"});
            end else begin
                push(ir, con, 0, 1, 0, S_ZLO|S_MARIN, {nm, ".T5"});
                if (op == 5'd0) begin
                    push(ir, con, 0, 1, 0,
                         S_RAMRD|S_MDRRD|S_MDRIN, {nm, ".T6"});
                    push(ir, con, 0, 1, 0,
                         S_MDROU|S_GRA|S_RIN, {nm, ".T7"});
                end else begin
                    push(ir, con, 0, 1, 0,
                         S_GRA|S_ROUT|S_MDRIN, {nm, ".T6"});
                    push(ir, con, 0, 1, 0, S_RAMWR, {nm, ".T7"});
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            push(ir, con, 0, 1, 0, S_GRA|S_ROUT|S_YIN, {nm, ".T3"});
            push(ir, con, 0, 1, a, S_GRB|S_ROUT|S_ZIN, {nm, ".T4"});
            push(ir, con, 0, 1, 0, S_ZLO|S_LOIN, {nm, ".T5"});
            push(ir, con, 0, 1, 0, S_ZHI|S_HIIN, {nm, ".T6"});
        end else if (op == 5'd17 || op == 5'd18) begin
            push(ir, con, 0, 1, a, S_GRB|S_ROUT|S_ZIN, {nm, ".T3"});
            push(ir, con, 0, 1, 0, S_ZLO|S_GRA|S_RIN, {nm, ".T4"});
        end else if (op == 5'd19) begin
            push(ir, con, 0, 1, 0, S_GRA|S_ROUT|S_CONIN, {nm, ".T3"});
            push(ir, con, 0, 1, 0, S_PCOUT|S_YIN, {nm, ".T4"});
            push(ir, con, 0, 1, A_ADD, S_COUT|S_ZIN, {nm, ".T5"});
            push(ir, con, 0, 1, 0,
                 con ? (S_CONRS|S_ZLO|S_PCIN) : S_CONRS, {nm, ".T6"});
        end else if (op == 5'd20) begin
            push(ir, con, 0, 1, 0, S_GRA|S_ROUT|S_PCIN, {nm, ".T3"});
        end else if (op == 5'd21) begin
            push(ir, con, 0, 1, 0, S_PCOUT|S_R15W, {nm, ".T3"});
            push(ir, con, 0, 1, 0, S_GRA|S_ROUT|S_PCIN, {nm, ".T4"});
        end else if (op == 5'd22) begin
            push(ir, con, 0, 1, 0, S_INP|S_GRA|S_RIN, {nm, ".T3"});
        end else if (op == 5'd23) begin
            push(ir, con, 0, 1, 0, S_GRA|S_ROUT|S_OUTP, {nm, ".T3"});
        end else if (op == 5'd24) begin
            push(ir, con, 0, 1, 0, S_HIOUT|S_GRA|S_RIN, {nm, ".T3"});
        end else if (op == 5'd25) begin
            push(ir, con, 0, 1, 0, S_LOOUT|S_GRA|S_RIN, {nm, ".T3"});
        end
    endtask

    task automatic test_reset();
        sb_t e;
        repeat (2) @(posedge clk);
        push(32'hD000_0000, 0, 1, 1, 0, 0, "rst.hold");
        push(32'hD000_0000, 0, 0, 1, 0, 0, "rst.release");
        push_instr(32'hD000_0000, 0, "rst.nop");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            IR = e.ir; CON = e.con; clr = e.clr;
            @(negedge clk);
            n_vec++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_alu_ops();
        sb_t e;
        push_instr(32'h1891_8000, 0, "add");
        push_instr(mk(5'd11, 4'd4, 4'd5, 19'h30000), 0, "shl");
        push_instr(mk(5'd12, 4'd2, 4'd3, 19'h00055), 0, "addi");
        push_instr(mk(5'd14, 4'd2, 4'd3, 19'h0000F), 0, "ori");
        push_instr(mk(5'd1,  4'd6, 4'd0, 19'h00077), 0, "ldi");
        push_instr(mk(5'd16, 4'd3, 4'd4, 19'h0), 0, "mul");
        push_instr(mk(5'd15, 4'd3, 4'd4, 19'h0), 0, "div");
        push_instr(mk(5'd17, 4'd1, 4'd2, 19'h0), 0, "neg");
        push_instr(mk(5'd18, 4'd1, 4'd2, 19'h0), 0, "not");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            IR = e.ir; CON = e.con; clr = e.clr;
            @(negedge clk);
            n_vec++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_mem();
        sb_t e;
        push_instr(mk(5'd2, 4'd1, 4'd0, 19'h00055), 0, "st");
        push_instr(mk(5'd0, 4'd2, 4'd0, 19'h00055), 0, "ld");
        push_instr(mk(5'd2, 4'd3, 4'd1, 19'h7FFFF), 0, "st2");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            IR = e.ir; CON = e.con; clr = e.clr;
            @(negedge clk);
            n_vec++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_branch_jump_io();
        sb_t e;
        push_instr(mk(5'd19, 4'd2, 4'd0, 19'h00010), 0, "br.c0");
        push_instr(mk(5'd19, 4'd2, 4'd0, 19'h00010), 1, "br.c1");
        push_instr(mk(5'd20, 4'd7, 4'd0, 19'h0), 0, "jr");
        push_instr(mk(5'd21, 4'd7, 4'd0, 19'h0), 0, "jal");
        push_instr(mk(5'd22, 4'd3, 4'd0, 19'h0), 0, "in");
        push_instr(mk(5'd23, 4'd3, 4'd0, 19'h0), 0, "out");
        push_instr(mk(5'd24, 4'd4, 4'd0, 19'h0), 0, "mfhi");
        push_instr(mk(5'd25, 4'd5, 4'd0, 19'h0), 0, "mflo");
        push_instr(mk(5'd26, 4'd0, 4'd0, 19'h0), 0, "nop");
        push_instr(mk(5'd30, 4'd1, 4'd2, 19'h0), 1, "undef");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            IR = e.ir; CON = e.con; clr = e.clr;
            @(negedge clk);
            n_vec++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_halt();
        sb_t e;
        push_instr(32'hD800_0000, 0, "halt");
        for (int i = 0; i < 20; i++)
            push(32'hD800_0000, 0, (i == 19), 0, 0, 0, "halt.idle");
        push(32'hD800_0000, 0, 0, 1, 0, 0, "halt.rst");
        push_instr(32'h1891_8000, 0, "halt.add");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            IR = e.ir; CON = e.con; clr = e.clr;
            @(negedge clk);
            n_vec++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_clr_mid();
        sb_t e;
        push_instr(mk(5'd0, 4'd2, 4'd0, 19'h00055), 0, "ldabort");
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        sb_q[sb_q.size()-1].clr = 1'b1;
        push(32'h1891_8000, 0, 0, 1, 0, 0, "ldabort.rst");
        push_instr(32'h1891_8000, 0, "ldabort.add");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            IR = e.ir; CON = e.con; clr = e.clr;
            @(negedge clk);
            n_vec++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch_jump_io();
        test_halt();
        test_clr_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
